// File: rtl/jtframe_mc2_pkg.sv
// Shared definitions for the Multicore 2 serial joystick front end.
package jtframe_mc2_pkg;

    // Serial reader sequence, one step per tick (ST_FRAME excepted)
    typedef enum logic [2:0] {
        ST_LOAD,
        ST_REL,
        ST_LOW,
        ST_HIGH,
        ST_SEL,
        ST_WAIT,
        ST_FRAME
    } joy_state_e;

    // Raw bits used per pad inside one page (low = pressed)
    localparam int unsigned PAD_RAW_W = 6;
    localparam int unsigned PAD_OUT_W = 8;

    // Raw bit positions within a pad's byte of a page
    localparam int unsigned BIT_UP    = 0;
    localparam int unsigned BIT_DOWN  = 1;
    localparam int unsigned BIT_LEFT  = 2;
    localparam int unsigned BIT_RIGHT = 3;
    localparam int unsigned BIT_P6    = 4;
    localparam int unsigned BIT_P9    = 5;

    // Bit positions inside joy*_o: {start,A,C,B,right,left,down,up}
    localparam int unsigned OUT_UP    = 0;
    localparam int unsigned OUT_DOWN  = 1;
    localparam int unsigned OUT_LEFT  = 2;
    localparam int unsigned OUT_RIGHT = 3;
    localparam int unsigned OUT_B     = 4;
    localparam int unsigned OUT_C     = 5;
    localparam int unsigned OUT_A     = 6;
    localparam int unsigned OUT_START = 7;

    // Decoded result for one pad
    typedef struct packed {
        logic [PAD_OUT_W-1:0] joy;
        logic                 md;
    } pad_dec_t;

endpackage

// File: rtl/jtframe_mc2_joydec.sv
// Combinational decode of one pad's two select pages into an active-high word.
module jtframe_mc2_joydec
    import jtframe_mc2_pkg::*;
(
    input  logic [PAD_RAW_W-1:0] p0,
    input  logic [PAD_RAW_W-1:0] p1,
    output pad_dec_t             dec_c
);

    logic md;

    // Mega Drive pads pull left and right low while select is low
    always_comb begin
        md                     = ~p1[BIT_LEFT] & ~p1[BIT_RIGHT];
        dec_c                  = '0;
        dec_c.md               = md;
        dec_c.joy[OUT_UP]      = ~p0[BIT_UP];
        dec_c.joy[OUT_DOWN]    = ~p0[BIT_DOWN];
        dec_c.joy[OUT_LEFT]    = ~p0[BIT_LEFT];
        dec_c.joy[OUT_RIGHT]   = ~p0[BIT_RIGHT];
        dec_c.joy[OUT_B]       = ~p0[BIT_P6];
        dec_c.joy[OUT_C]       = ~p0[BIT_P9];
        dec_c.joy[OUT_A]       = md & ~p1[BIT_P6];
        dec_c.joy[OUT_START]   = md & ~p1[BIT_P9];
    end

endmodule

// File: rtl/jtframe_mc2_joyser.sv
// Multicore 2 serial joystick reader: drives the 74HC165 chain, reads two
// select pages per frame and publishes filtered active-high pad words.
module jtframe_mc2_joyser
    import jtframe_mc2_pkg::*;
#(
    parameter int unsigned DIV    = 8,
    parameter int unsigned SETTLE = 4,
    parameter int unsigned NBITS  = 16
) (
    input  logic       clk_sys,
    input  logic       rst,
    output logic       joy_clock_o,
    output logic       joy_load_o,
    output logic       joyX_p7_o,
    input  logic       joy_data_i,
    output logic [7:0] joy1_o,
    output logic [7:0] joy2_o,
    output logic [1:0] md_pad_o,
    output logic       valid_o
);

    localparam int unsigned DIV_W   = $clog2(DIV);
    localparam int unsigned CNT_W   = $clog2(NBITS);
    localparam int unsigned SET_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned FRAME_W = 2 * NBITS;

    joy_state_e         state_q, state_d;
    logic [DIV_W-1:0]   div_q;
    logic               tick_c;
    logic [CNT_W-1:0]   bit_q, bit_d;
    logic [SET_W-1:0]   set_q, set_d;
    logic               page_q, page_d;
    logic [NBITS-1:0]   pg0_q, pg0_d, pg1_q, pg1_d;
    logic               clock_d, load_d, p7_d;
    logic               frame_end_c;
    logic [FRAME_W-1:0] prev_q;
    logic               have_prev_q;
    logic [FRAME_W-1:0] frame_c;
    pad_dec_t           dec1_c, dec2_c;

    assign tick_c  = (div_q == DIV_W'(DIV - 1));
    assign frame_c = {pg1_q, pg0_q};

    // Tick divider; held during the single-cycle FRAME step
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else if (state_q == ST_FRAME || tick_c) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Sequencer state and registered chain controls
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            bit_q       <= '0;
            set_q       <= '0;
            page_q      <= 1'b0;
            pg0_q       <= '1;
            pg1_q       <= '1;
            joy_clock_o <= 1'b0;
            joy_load_o  <= 1'b1;
            joyX_p7_o   <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            set_q       <= set_d;
            page_q      <= page_d;
            pg0_q       <= pg0_d;
            pg1_q       <= pg1_d;
            joy_clock_o <= clock_d;
            joy_load_o  <= load_d;
            joyX_p7_o   <= p7_d;
        end
    end

    // Next-state and chain control decode
    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        set_d       = set_q;
        page_d      = page_q;
        pg0_d       = pg0_q;
        pg1_d       = pg1_q;
        clock_d     = joy_clock_o;
        load_d      = joy_load_o;
        p7_d        = joyX_p7_o;
        frame_end_c = 1'b0;
        case (state_q)
            ST_LOAD: if (tick_c) begin
                load_d  = 1'b0;
                state_d = ST_REL;
            end
            ST_REL: if (tick_c) begin
                load_d  = 1'b1;
                bit_d   = '0;
                state_d = ST_LOW;
            end
            ST_LOW: if (tick_c) begin
                clock_d = 1'b0;
                if (page_q) pg1_d[bit_q] = joy_data_i;
                else        pg0_d[bit_q] = joy_data_i;
                state_d = ST_HIGH;
            end
            ST_HIGH: if (tick_c) begin
                clock_d = 1'b1;
                if (bit_q == CNT_W'(NBITS - 1)) begin
                    state_d = ST_SEL;
                end else begin
                    bit_d   = bit_q + CNT_W'(1);
                    state_d = ST_LOW;
                end
            end
            ST_SEL: if (tick_c) begin
                clock_d = 1'b0;
                p7_d    = ~joyX_p7_o;
                set_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: if (tick_c) begin
                if (set_q == SET_W'(SETTLE - 1)) begin
                    if (page_q) begin
                        state_d = ST_FRAME;
                    end else begin
                        page_d  = 1'b1;
                        state_d = ST_LOAD;
                    end
                end else begin
                    set_d = set_q + SET_W'(1);
                end
            end
            ST_FRAME: begin
                frame_end_c = 1'b1;
                page_d      = 1'b0;
                state_d     = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    jtframe_mc2_joydec u_dec1 (
        .p0    (pg0_q[PAD_RAW_W-1:0]),
        .p1    (pg1_q[PAD_RAW_W-1:0]),
        .dec_c (dec1_c)
    );

    jtframe_mc2_joydec u_dec2 (
        .p0    (pg0_q[8 +: PAD_RAW_W]),
        .p1    (pg1_q[8 +: PAD_RAW_W]),
        .dec_c (dec2_c)
    );

    // Two-frame agreement filter; the first frame after reset never publishes
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            prev_q      <= '1;
            have_prev_q <= 1'b0;
            joy1_o      <= '0;
            joy2_o      <= '0;
            md_pad_o    <= '0;
            valid_o     <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (frame_end_c) begin
                prev_q      <= frame_c;
                have_prev_q <= 1'b1;
                if (have_prev_q && frame_c == prev_q) begin
                    joy1_o   <= dec1_c.joy;
                    joy2_o   <= dec2_c.joy;
                    md_pad_o <= {dec2_c.md, dec1_c.md};
                    valid_o  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtframe_mc2_joyser.sv
// Bench: models the pads and shift chain, predicts outputs per frame.
module tb_jtframe_mc2_joyser;

    localparam int unsigned DIV       = 8;
    localparam int unsigned SETTLE    = 4;
    localparam int unsigned FRAME_CYC = (70 + 2 * SETTLE) * DIV + 1;
    localparam int          NF        = 30;
    localparam int unsigned RST_AT    = 8 * 42 + 4;

    logic       clk_sys = 1'b0;
    logic       rst     = 1'b1;
    logic       joy_clock_o, joy_load_o, joyX_p7_o;
    logic       joy_data_i = 1'b1;
    logic [7:0] joy1_o, joy2_o;
    logic [1:0] md_pad_o;
    logic       valid_o;

    always #5 clk_sys = ~clk_sys;

    jtframe_mc2_joyser #(.DIV(DIV), .SETTLE(SETTLE), .NBITS(16)) dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .joy_clock_o (joy_clock_o),
        .joy_load_o  (joy_load_o),
        .joyX_p7_o   (joyX_p7_o),
        .joy_data_i  (joy_data_i),
        .joy1_o      (joy1_o),
        .joy2_o      (joy2_o),
        .md_pad_o    (md_pad_o),
        .valid_o     (valid_o)
    );

    int vectors     = 0;
    int miscompares = 0;
    int n           = 0;

    // Raw page words per frame (index = frame number since reset, from 1)
    logic [15:0] fr0 [0:NF+1];
    logic [15:0] fr1 [0:NF+1];
    logic        lit_en [0:NF+1];
    logic [18:0] lit    [0:NF+1];

    logic [7:0]  exp_j1, exp_j2;
    logic [1:0]  exp_md;
    logic        exp_v;
    logic [15:0] sr;
    logic        clk_q, load_q, seen_load, seen_valid;
    int          load_run, rises;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, n, act, req);
        end
    endtask

    // Pad decode from the board's pin rules; returns {md, joy}
    function automatic logic [8:0] pad_model(input logic [7:0] w0, input logic [7:0] w1);
        logic md;
        md = (w1[2] == 1'b0) && (w1[3] == 1'b0);
        return {md, md && !w1[5], md && !w1[4], ~w0[5:0]};
    endfunction

    task automatic reset_model();
        exp_j1 = '0; exp_j2 = '0; exp_md = '0; exp_v = 1'b0;
        sr = 16'hFFFF; clk_q = 1'b0; load_q = 1'b1;
        seen_load = 1'b0; seen_valid = 1'b0; load_run = 0; rises = 0;
    endtask

    task automatic step();
        int k, cur;
        logic [8:0] d1, d2;
        logic rise;
        @(posedge clk_sys);
        n++;
        @(negedge clk_sys);
        k   = n / int'(FRAME_CYC);
        cur = k + 1;
        exp_v = 1'b0;
        if (n % int'(FRAME_CYC) == 0 && k >= 2) begin
            if ({fr1[k], fr0[k]} == {fr1[k-1], fr0[k-1]}) begin
                d1 = pad_model(fr0[k][7:0],  fr1[k][7:0]);
                d2 = pad_model(fr0[k][15:8], fr1[k][15:8]);
                exp_j1 = d1[7:0];
                exp_j2 = d2[7:0];
                exp_md = {d2[8], d1[8]};
                exp_v  = 1'b1;
            end
        end
        check("outputs", {13'd0, valid_o, md_pad_o, joy2_o, joy1_o},
                         {13'd0, exp_v, exp_md, exp_j2, exp_j1});
        if (n % int'(FRAME_CYC) == 0 && k >= 1 && k <= NF && lit_en[k])
            check("literal", {13'd0, valid_o, md_pad_o, joy2_o, joy1_o}, {13'd0, lit[k]});
        if (valid_o === 1'b1 && !seen_valid) begin
            seen_valid = 1'b1;
            check("first_valid", n, 2 * FRAME_CYC);
        end
        // Load pulse width and clock edges per page
        rise = joy_clock_o && !clk_q;
        if (joy_load_o === 1'b0) begin
            if (load_q) begin
                if (seen_load) check("clk_edges", rises, 16);
                seen_load = 1'b1;
                rises     = 0;
            end
            load_run++;
        end else if (load_run != 0) begin
            check("load_width", load_run, DIV);
            load_run = 0;
        end
        if (rise) rises++;
        // 74HC165 chain: transparent while loading, shifts on rising clock
        if (!joy_load_o)  sr = joyX_p7_o ? fr0[cur] : fr1[cur];
        else if (rise)    sr = {1'b1, sr[15:1]};
        clk_q      = joy_clock_o;
        load_q     = joy_load_o;
        joy_data_i = sr[0];
    endtask

    initial begin
        for (int k = 0; k <= NF + 1; k++) begin
            fr0[k] = 16'hFFFF; fr1[k] = 16'hFFFF; lit_en[k] = 1'b0; lit[k] = '0;
        end
        fr0[3] = 16'hFFFE; fr1[3] = 16'hFFFE; fr0[4] = 16'hFFFE; fr1[4] = 16'hFFFE;
        fr0[5] = 16'hEFFF; fr1[5] = 16'hD3FF; fr0[6] = 16'hEFFF; fr1[6] = 16'hD3FF;
        fr0[7] = 16'hFFDF; fr1[7] = 16'hFFDF; fr0[8] = 16'hFFDF; fr1[8] = 16'hFFDF;
        for (int k = 9; k <= 14; k++) begin
            fr0[k] = (k % 2 == 1) ? 16'hFFFE : 16'hFFFD;
            fr1[k] = fr0[k];
        end
        fr0[15] = 16'hFFFB; fr1[15] = 16'hFFFB; fr0[16] = 16'hFFFB; fr1[16] = 16'hFFFB;
        for (int k = 17; k <= NF - 2; k++) begin
            if ($urandom_range(1, 0) == 0) begin
                fr0[k] = fr0[k-1]; fr1[k] = fr1[k-1];
            end else begin
                fr0[k] = 16'($urandom);
                fr1[k] = 16'($urandom);
                if ($urandom_range(1, 0) == 1) fr1[k] = fr1[k] & 16'hF3FF;
                if ($urandom_range(1, 0) == 1) fr1[k] = fr1[k] & 16'hFFF3;
            end
        end
        for (int k = NF - 1; k <= NF + 1; k++) begin
            fr0[k] = 16'hFFFE; fr1[k] = 16'hFFFE;
        end
        // {valid, md, joy2, joy1}
        lit_en[2]  = 1'b1; lit[2]  = {1'b1, 2'b00, 8'h00, 8'h00};
        lit_en[4]  = 1'b1; lit[4]  = {1'b1, 2'b00, 8'h00, 8'h01};
        lit_en[6]  = 1'b1; lit[6]  = {1'b1, 2'b10, 8'h90, 8'h00};
        lit_en[8]  = 1'b1; lit[8]  = {1'b1, 2'b00, 8'h00, 8'h20};
        lit_en[15] = 1'b1; lit[15] = {1'b0, 2'b00, 8'h00, 8'h20};
        lit_en[16] = 1'b1; lit[16] = {1'b1, 2'b00, 8'h00, 8'h04};
        lit_en[NF] = 1'b1; lit[NF] = {1'b1, 2'b00, 8'h00, 8'h01};

        reset_model();
        rst = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("reset_state", {13'd0, joy_clock_o, joy_load_o, joyX_p7_o, valid_o, md_pad_o, joy2_o, joy1_o},
                             {13'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00});
        rst = 1'b0;
        n   = 0;
        repeat (NF * int'(FRAME_CYC) + int'(RST_AT)) step();

        // Mid-page-1 asynchronous reset
        check("p7_page1", {31'd0, joyX_p7_o}, 32'd0);
        #2 rst = 1'b1;
        #1 check("reset_async", {13'd0, joy_clock_o, joy_load_o, joyX_p7_o, valid_o, md_pad_o, joy2_o, joy1_o},
                                {13'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00});
        @(negedge clk_sys);
        rst = 1'b0;
        reset_model();
        n = 0;
        for (int k = 0; k <= NF + 1; k++) begin
            fr0[k] = 16'hFFFF; fr1[k] = 16'hFFFF; lit_en[k] = 1'b0;
        end
        lit_en[2] = 1'b1; lit[2] = {1'b1, 2'b00, 8'h00, 8'h00};
        repeat (3 * int'(FRAME_CYC)) step();
        check("restart_valid", {31'd0, seen_valid}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
